hsdaoh_counter_checker: RTL
===========================

// Module: hsdaoh_counter_checker
// PURPOSE
// Reader-side counterpart of the free-running 16-bit test counter that feeds the data FIFO.
// - Drains the dual-clock FIFO on its read (pixel) clock domain.
// - Checks that words form the +1 sequence and counts words and sequence errors.
// - Locks onto the stream and re-acquires after sustained loss.
// - Used in loopback/bring-up builds in place of hsdaoh_core as the FIFO consumer,
//   to verify FIFO and data-clock integrity.
// PARAMETERS
// DATA_WIDTH    16  width of data_in and of the expected counter
// READ_LATENCY  1   cycles from fifo_read_en high to data_in valid (1 = non-FWFT FIFO); legal range 1..4
// LOSS_THRESH   4   consecutive mismatches that drop lock; legal range 1..255
// CNT_WIDTH     32  width of err_count and word_count
// PORTS
// clk_pixel      in   1           FIFO read clock; all logic on its rising edge
// rstn           in   1           asynchronous active-low reset
// enable         in   1           run checker; low forces IDLE
// clear          in   1           synchronous clear of statistics
// fifo_empty     in   1           FIFO empty flag
// fifo_read_en   out  1           FIFO read strobe
// data_in        in   DATA_WIDTH  FIFO read data
// locked         out  1           high while in LOCKED
// err_flag       out  1           one-cycle pulse per mismatch
// err_count      out  CNT_WIDTH   saturating mismatch count
// word_count     out  CNT_WIDTH   saturating count of words checked in LOCKED
// last_expected  out  DATA_WIDTH  expected value at most recent mismatch
// last_received  out  DATA_WIDTH  received value at most recent mismatch
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; read-valid pipeline 0; expected 0; miss_run 0.
// - fifo_read_en = enable & ~fifo_empty & (state != IDLE). Combinational.
//   - Never asserted while fifo_empty=1.
//   - Low during reset.
// - Valid pipeline: READ_LATENCY-deep shift register of fifo_read_en.
//   - Its tail (rd_vld) marks data_in valid.
//   - It always shifts, including in IDLE.
// - FSM states: IDLE, ACQUIRE, LOCKED.
//   - enable=0: IDLE from any state, next cycle.
//     - In-flight words arriving in IDLE are discarded.
//     - miss_run <= 0.
//   - IDLE & enable=1 -> ACQUIRE.
//   - ACQUIRE & rd_vld -> LOCKED, expected <= data_in+1.
//     - This seed word is not counted or compared.
//   - LOCKED & rd_vld & data_in==expected:
//     - word_count++.
//     - expected <= expected+1.
//     - miss_run <= 0.
//   - LOCKED & rd_vld & mismatch:
//     - word_count++ and err_count++.
//     - err_flag=1 for the next cycle.
//     - last_expected <= expected; last_received <= data_in.
//     - expected <= data_in+1 (re-seed, so one dropped word = exactly 1 error).
//     - miss_run++.
//     - If miss_run+1 == LOSS_THRESH: -> ACQUIRE, miss_run <= 0.
// - Arithmetic is modulo 2^DATA_WIDTH: expected 0xFFFF followed by data 0x0000 is a match.
// - err_count and word_count saturate at all-ones and never wrap.
// - locked is registered and equals (state==LOCKED); it drops the cycle after the transition.
// - clear=1 zeroes err_count, word_count, last_expected, last_received and err_flag.
//   - clear wins over a same-cycle mismatch or count increment.
//   - State, expected and miss_run are unaffected by clear.
// - rstn asserted mid-stream: immediate return to reset values.
//   - Words already read are lost; the next run re-acquires.
// TESTING
// 1. Counter source 0x0000.. for 1000 words, FIFO never empty:
//    -> locked after first word; word_count=999; err_count=0.
// 2. Seed 0xFFF0, run 40 words:
//    -> wrap 0xFFFF->0x0000 yields no error; word_count=39.
// 3. Drop word 0x0105 from sequence:
//    -> err_count=1; last_expected=0x0105; last_received=0x0106; next words clean.
// 4. LOSS_THRESH=4, inject random words for 4 cycles:
//    -> locked falls; FSM reaches ACQUIRE; relocks on next clean word; err_count=4.
// 5. fifo_empty toggled randomly, READ_LATENCY=1 and 2:
//    -> fifo_read_en never high while empty; no false errors.
// 6. clear coincident with a mismatch; rstn pulsed mid-run:
//    -> err_count=0 after clear; all outputs 0 after reset, relock on resume.

Source files
------------

// File: rtl/hsdaoh_counter_checker.sv
// Read-side checker for the 16-bit test counter stream: drains the data FIFO, verifies
// the +1 sequence, tracks lock, and keeps saturating word/error statistics.
module hsdaoh_counter_checker #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned LOSS_THRESH  = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                  clk_pixel,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  locked,
    output logic                  err_flag,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [DATA_WIDTH-1:0] last_expected,
    output logic [DATA_WIDTH-1:0] last_received
);

    localparam int unsigned MISS_W = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } state_e;

    state_e                  state_q, state_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   expected_q, expected_d;
    logic [MISS_W-1:0]       miss_run_q, miss_run_d;
    logic                    locked_q, locked_d;
    logic                    err_flag_q, err_flag_d;
    logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;
    logic [CNT_WIDTH-1:0]    word_count_q, word_count_d;
    logic [DATA_WIDTH-1:0]   last_exp_q, last_exp_d;
    logic [DATA_WIDTH-1:0]   last_rcv_q, last_rcv_d;
    logic                    rd_vld;

    assign fifo_read_en = enable & ~fifo_empty & (state_q != ST_IDLE);
    assign rd_vld       = vld_q[READ_LATENCY-1];

    // Read-valid delay line; keeps shifting in every state so stale reads drain out.
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = fifo_read_en;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        miss_run_d   = miss_run_q;
        err_flag_d   = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        last_exp_d   = last_exp_q;
        last_rcv_d   = last_rcv_q;

        if (!enable) begin
            state_d    = ST_IDLE;
            miss_run_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (rd_vld) begin
                        state_d    = ST_LOCKED;
                        expected_d = data_in + DATA_WIDTH'(1);
                    end
                end
                ST_LOCKED: begin
                    if (rd_vld) begin
                        if (word_count_q != CNT_MAX) word_count_d = word_count_q + CNT_WIDTH'(1);
                        if (data_in == expected_q) begin
                            expected_d = expected_q + DATA_WIDTH'(1);
                            miss_run_d = '0;
                        end else begin
                            // Re-seed from the received word so a single drop costs one error.
                            if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_WIDTH'(1);
                            err_flag_d = 1'b1;
                            last_exp_d = expected_q;
                            last_rcv_d = data_in;
                            expected_d = data_in + DATA_WIDTH'(1);
                            if (miss_run_q + MISS_W'(1) == MISS_W'(LOSS_THRESH)) begin
                                state_d    = ST_ACQUIRE;
                                miss_run_d = '0;
                            end else begin
                                miss_run_d = miss_run_q + MISS_W'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clear) begin
            err_flag_d   = 1'b0;
            err_count_d  = '0;
            word_count_d = '0;
            last_exp_d   = '0;
            last_rcv_d   = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            vld_q        <= '0;
            expected_q   <= '0;
            miss_run_q   <= '0;
            locked_q     <= 1'b0;
            err_flag_q   <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
            last_exp_q   <= '0;
            last_rcv_q   <= '0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            expected_q   <= expected_d;
            miss_run_q   <= miss_run_d;
            locked_q     <= locked_d;
            err_flag_q   <= err_flag_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            last_exp_q   <= last_exp_d;
            last_rcv_q   <= last_rcv_d;
        end
    end

    assign locked        = locked_q;
    assign err_flag      = err_flag_q;
    assign err_count     = err_count_q;
    assign word_count    = word_count_q;
    assign last_expected = last_exp_q;
    assign last_received = last_rcv_q;

endmodule
